// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the display encoder and seg_reader.
// Patterns are active-low, bit6=a .. bit0=g.
package seg_pkg;
  localparam int SEG_W = 7;
  localparam int VAL_W = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;

  localparam logic [SEG_W-1:0] SIGN_NEG = 7'b1111110;
  localparam logic [SEG_W-1:0] SIGN_POS = 7'b1111111;
endpackage

// File: rtl/seg_digit_decode.sv
// Combinational magnitude digit decode: pattern -> {valid, mag}.
// Unknown patterns report valid=0 and mag=0.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic             valid,
  output logic [2:0]       mag
);
  always_comb begin
    valid = 1'b1;
    mag   = 3'd0;
    case (pat)
      SEG_0:   mag = 3'd0;
      SEG_1:   mag = 3'd1;
      SEG_2:   mag = 3'd2;
      SEG_3:   mag = 3'd3;
      SEG_4:   mag = 3'd4;
      SEG_5:   mag = 3'd5;
      SEG_6:   mag = 3'd6;
      SEG_7:   mag = 3'd7;
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_reader.sv
// Two-digit seven-segment reader: stability filter, decode back to a
// signed 4-bit value, deliver each new value once via valid/ready.
module seg_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [SEG_W-1:0] seg0_in,
  input  logic [SEG_W-1:0] seg1_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_value,
  output logic             out_err,
  output logic             drop
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  logic [2*SEG_W-1:0] pair;
  logic [2*SEG_W-1:0] sreg;
  logic [7:0]         cnt;
  logic [7:0]         cnt_nx;
  logic               same;
  logic               accept;
  logic               dig_ok;
  logic [2:0]         mag;
  logic               pos;
  logic               neg;
  logic               err;
  logic [VAL_W-1:0]   value;
  logic [VAL_W:0]     last;
  logic               emitted_any;
  logic               event_fire;
  logic               load;

  seg_digit_decode u_dig (
    .pat   (seg0_in),
    .valid (dig_ok),
    .mag   (mag)
  );

  assign pair = {seg1_in, seg0_in};
  assign same = (pair == sreg);
  assign pos  = (seg1_in == SIGN_POS);
  assign neg  = (seg1_in == SIGN_NEG);

  always_comb begin
    cnt_nx = 8'd1;
    if (same)
      cnt_nx = (cnt == SC) ? cnt : cnt + 8'd1;
  end

  // A held, saturated pattern never re-fires; only a fresh run does.
  assign accept = sample_en && (cnt_nx == SC)
               && (!same || cnt != SC);

  always_comb begin
    err   = !dig_ok || !(pos || neg);
    value = '0;
    if (!err) begin
      if (pos)
        value = {1'b0, mag};
      else if (mag == 3'd0)
        value = 4'b1000;
      else
        value = (~{1'b0, mag}) + 4'd1;
    end
  end

  assign event_fire = accept
    && !(emitted_any && ({err, value} == last));
  assign load = event_fire && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg        <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_value   <= '0;
      out_err     <= 1'b0;
      drop        <= 1'b0;
      last        <= '0;
      emitted_any <= 1'b0;
    end else begin
      if (sample_en) begin
        sreg <= pair;
        cnt  <= cnt_nx;
      end
      drop <= event_fire && out_valid && !out_ready;
      if (load) begin
        out_valid   <= 1'b1;
        out_value   <= value;
        out_err     <= err;
        last        <= {err, value};
        emitted_any <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg_reader.sv
// Self-checking bench for seg_reader: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_seg_reader;
  import seg_pkg::*;

  localparam int S = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_en = 1'b0;
  logic [SEG_W-1:0] seg0_in = '1;
  logic [SEG_W-1:0] seg1_in = '1;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [VAL_W-1:0] out_value;
  logic             out_err;
  logic             drop;

  int checks = 0;
  int failures = 0;

  seg_reader #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .seg0_in   (seg0_in),
    .seg1_in   (seg1_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [6:0]  pats [8];
  logic [13:0] m_prev;
  int          m_run;
  logic        m_valid;
  logic [3:0]  m_val;
  logic        m_err;
  logic        m_drop;
  logic        m_any;
  logic [4:0]  m_last;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic decode(input logic [6:0] s1,
                        input logic [6:0] s0,
                        output logic e,
                        output logic [3:0] v);
    int mag;
    int val;
    mag = -1;
    for (int i = 0; i < 8; i++)
      if (pats[i] == s0) mag = i;
    e = 1'b0;
    v = 4'd0;
    if (mag < 0 || (s1 != SIGN_POS && s1 != SIGN_NEG)) begin
      e = 1'b1;
    end else begin
      val = (s1 == SIGN_NEG) ? -mag : mag;
      if (s1 == SIGN_NEG && mag == 0) val = -8;
      v = val[3:0];
    end
  endtask

  task automatic model(input logic r, input logic en,
                       input logic [6:0] s1,
                       input logic [6:0] s0,
                       input logic rdy);
    logic acc;
    logic e;
    logic [3:0] v;
    logic ev;
    if (r) begin
      m_prev = '0; m_run = 0; m_valid = 0; m_val = '0;
      m_err = 0; m_drop = 0; m_any = 0; m_last = '0;
      return;
    end
    acc = 1'b0;
    if (en) begin
      if ({s1, s0} == m_prev) m_run++;
      else begin
        m_prev = {s1, s0};
        m_run = 1;
      end
      acc = (m_run == S);
    end
    decode(s1, s0, e, v);
    ev = acc && !(m_any && {e, v} == m_last);
    m_drop = ev && m_valid && !rdy;
    if (ev && (!m_valid || rdy)) begin
      m_valid = 1; m_val = v; m_err = e;
      m_last = {e, v}; m_any = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic r, input logic en,
                      input logic [6:0] s1,
                      input logic [6:0] s0,
                      input logic rdy);
    rst = r; sample_en = en;
    seg1_in = s1; seg0_in = s0; out_ready = rdy;
    @(posedge clk);
    model(r, en, s1, s0, rdy);
    #1;
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("value", 32'(out_value), 32'(m_val));
    chk("err", 32'(out_err), 32'(m_err));
    chk("drop", 32'(drop), 32'(m_drop));
  endtask

  task automatic hold(input int n, input logic en,
                      input logic [6:0] s1,
                      input logic [6:0] s0,
                      input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, en, s1, s0, rdy);
  endtask

  initial begin
    int drops;
    logic [6:0] s0r;
    logic [6:0] s1r;
    pats[0] = SEG_0; pats[1] = SEG_1; pats[2] = SEG_2;
    pats[3] = SEG_3; pats[4] = SEG_4; pats[5] = SEG_5;
    pats[6] = SEG_6; pats[7] = SEG_7;

    step(1'b1, 1'b0, SIGN_POS, SEG_0, 1'b1);
    step(1'b1, 1'b0, SIGN_POS, SEG_0, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_value", 32'(out_value), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);

    // +2: valid after the 4th sample, then one transfer
    hold(3, 1'b1, SIGN_POS, SEG_2, 1'b1);
    chk("t1_early", 32'(out_valid), 32'd0);
    hold(1, 1'b1, SIGN_POS, SEG_2, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_value", 32'(out_value), 32'h2);
    hold(3, 1'b1, SIGN_POS, SEG_2, 1'b1);
    chk("t1_once", 32'(out_valid), 32'd0);

    // negative values, including -0 -> -8
    hold(4, 1'b1, SIGN_NEG, SEG_0, 1'b1);
    chk("neg8", 32'(out_value), 32'h8);
    hold(4, 1'b1, SIGN_NEG, SEG_1, 1'b1);
    chk("neg1", 32'(out_value), 32'hF);
    hold(4, 1'b1, SIGN_NEG, SEG_7, 1'b1);
    chk("neg7", 32'(out_value), 32'h9);

    // glitch back to the same value
    hold(5, 1'b1, SIGN_POS, SEG_3, 1'b1);
    chk("g3", 32'(out_value), 32'h3);
    hold(2, 1'b1, SIGN_POS, SEG_5, 1'b1);
    hold(10, 1'b1, SIGN_POS, SEG_3, 1'b1);
    chk("g_none", 32'(out_value), 32'h3);

    // invalid pair, then a different invalid pair
    hold(4, 1'b1, SIGN_POS, 7'b1111111, 1'b1);
    chk("inv_err", 32'(out_err), 32'd1);
    chk("inv_val", 32'(out_value), 32'd0);
    hold(6, 1'b1, 7'b0000000, 7'b1111111, 1'b1);

    // backpressure and drop
    hold(6, 1'b1, SIGN_POS, SEG_1, 1'b0);
    hold(4, 1'b1, SIGN_POS, SEG_2, 1'b0);
    chk("bp_drop", 32'(drop), 32'd1);
    chk("bp_hold", 32'(out_value), 32'h1);
    hold(1, 1'b1, SIGN_POS, SEG_2, 1'b0);
    chk("bp_pulse", 32'(drop), 32'd0);
    hold(3, 1'b1, SIGN_POS, SEG_2, 1'b1);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // gated sampling, then reset while holding an event
    for (int i = 0; i < 7; i++)
      step(1'b0, (i % 2) == 0, SIGN_POS, SEG_4, 1'b0);
    chk("en_val", 32'(out_value), 32'h4);
    chk("en_valid", 32'(out_valid), 32'd1);
    step(1'b1, 1'b1, SIGN_POS, SEG_4, 1'b0);
    chk("rst_mid", 32'(out_valid), 32'd0);
    hold(4, 1'b1, SIGN_POS, SEG_4, 1'b1);
    chk("re_emit", 32'(out_valid), 32'd1);
    chk("re_val", 32'(out_value), 32'h4);

    // random traffic
    drops = 0;
    for (int k = 0; k < 400; k++) begin
      int r0;
      int r1;
      int n;
      r0 = $urandom_range(0, 9);
      r1 = $urandom_range(0, 5);
      s0r = (r0 < 8) ? pats[r0] : ((r0 == 8) ? 7'h7F : 7'h00);
      s1r = (r1 < 3) ? SIGN_POS
          : (r1 < 5) ? SIGN_NEG : 7'h00;
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 4) != 0), s1r, s0r,
             ($urandom_range(0, 2) != 0));
        if (m_drop) drops++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_reader.md
Name: seg_reader

Overview:
- Reverse path of the adder's two-digit seven-segment display encoder.
- Samples the two active-low segment buses: seg0_in is the magnitude digit, seg1_in is the sign digit.
- Each pattern must be stable for STABLE_CYCLES samples before it is accepted. An accepted pattern is decoded back to the original signed 4-bit value.
- Each new value is delivered once through a valid/ready output register.
- Used as a self-check/loopback monitor beside the display driver and as an input decoder for captured display traffic.

Parameters:
STABLE_CYCLES, 4, consecutive identical enabled samples required to accept a pattern; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
sample_en  input  1  sample strobe; seg inputs are considered only in cycles where it is 1
seg0_in  input  7  magnitude digit, active-low, bit6=a .. bit0=g
seg1_in  input  7  sign digit, active-low, same bit order
out_valid  output  1  out_value/out_err hold an undelivered event
out_ready  input  1  consumer accepts the event when out_valid && out_ready
out_value  output  4  decoded two's-complement value
out_err  output  1  event came from an undecodable pattern pair
drop  output  1  one-cycle pulse: event discarded because the output register was full

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: out_valid=0, out_value=0, out_err=0, drop=0. Stability counter=0, sample register=0, emitted_any=0.
- Magnitude decode of seg0_in:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - any other pattern is invalid.
- Sign decode of seg1_in: 1111111=positive, 1111110=negative, any other pattern is invalid.
- Value reconstruction:
  - positive: {1'b0, mag}
  - negative: (~{1'b0, mag}) + 1, truncated to 4 bits
  - negative with mag 0 ("-0") decodes to 4'b1000 (-8). This matches the encoder's wrap for -8.
  - If either digit is invalid: out_err=1, out_value=4'b0000.
- Stability filter, applied only when sample_en=1:
  - If {seg1_in, seg0_in} equals the sample register, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the new pair is latched into the sample register and the counter is set to 1.
  - When sample_en=0, all filter state holds.
- Acceptance event:
  - Fires in the sampling cycle where the counter's next value first equals STABLE_CYCLES.
  - With STABLE_CYCLES=1, this is every sample that differs from the previous one, plus the first sample after reset.
  - The event is suppressed if emitted_any=1 and {err, value} equals last_emitted.
- Latency: the output register loads on the clock edge ending the accepting cycle, so out_valid rises in the next cycle.
- Output register and handshake:
  - Loads when it is empty or is being transferred in the same cycle (out_valid && out_ready). Back-to-back events therefore need no bubble.
  - On load: last_emitted<={err, value} and emitted_any<=1.
  - While out_valid && !out_ready, out_value and out_err must stay stable.
  - After a transfer with no new event, out_valid falls next cycle. out_value and out_err keep their old values.
- Full condition: an event while out_valid && !out_ready is discarded.
  - drop pulses high for exactly one cycle.
  - last_emitted is not updated.
  - The filter counter stays saturated, so the same pattern is not re-emitted until the pattern changes.
- Reset mid-operation clears any pending output and the filter. The first stable pattern after reset is always emitted, even if it equals the last pre-reset value.
- rst has priority over sample_en and out_ready in the same cycle.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_W=7
  - the eight magnitude patterns (SEG_0 .. SEG_7)
  - SIGN_NEG=7'b1111110 and SIGN_POS=7'b1111111
  - value width VAL_W=4
- The display encoder and seg_reader must both use this package.
- One natural sub-module, seg_digit_decode: combinational 7-bit pattern -> {valid, mag[2:0]}. It is instantiated once for seg0_in; sign decode stays inline.

Test Plan:
- Reset, then seg1=1111111, seg0=0010010, sample_en=1 held for 4 cycles, out_ready=1 -> one event with out_value=0010, out_err=0; out_valid rises the cycle after the 4th sample; exactly one transfer.
- seg1=1111110, seg0=0000001 held stable -> out_value=1000 (-8). Then seg0=1001111 -> out_value=1111 (-1). Then seg0=0001111 -> out_value=1001 (-7).
- Glitch: stable 3 (0000110) accepted; then pattern 0100100 for 2 samples, then back to 0000110 for 10 samples -> no new event (no acceptance of 5, value equals last); drop stays 0.
- Invalid: seg0=1111111 with seg1=1111111 held 4 samples -> out_err=1, out_value=0000. seg1=0000000 -> no second event, since {err, value} is the same.
- Backpressure: out_ready=0; accept +1, then stable +2 -> drop pulses 1 cycle, out_value stays 0001. Raise out_ready -> +1 transferred, no +2.
- sample_en toggling 1-0-1-0 with stable +4 -> event only after the 4th enabled sample. rst asserted while out_valid=1 -> out_valid=0 next cycle; the same +4 re-held is emitted again.
